// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the RV32 fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Sequencer states. Width is fixed so the encoding is stable across tools.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        COMMIT = 3'd3,
        HALT   = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF      = 32'h0000_1000;
    localparam logic [31:0] TRAP_VEC_DEF      = 32'h0000_0100;
    localparam int          FETCH_TIMEOUT_DEF = 16;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    // A fetch target must sit on a 4-byte instruction boundary.
    function automatic logic is_misaligned(input logic [31:0] i_addr);
        return (i_addr[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : fetch_watchdog
// Brief    : Counts non-stalled FETCH cycles that have no imem_valid and flags
//            the cycle that would make the count reach FETCH_TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int                c_cnt_w = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FETCH_TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Count qualifying cycles; saturate so a late reaction can never wrap it.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is flagged combinationally on the cycle that is the last allowed
    // one, so the sequencer faults exactly after FETCH_TIMEOUT idle cycles.
    assign o_expired = i_count && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Multicycle RV32 instruction-fetch controller. Runs the imem
//            handshake, hands instructions to execute and commits the next
//            PC, with fetch watchdog, misaligned-target trap, halt and
//            retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
    parameter logic [31:0] TRAP_VEC      = TRAP_VEC_DEF,
    parameter int          FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        misalign_trap,
    output logic        fetch_fault,
    output logic        halted,
    output logic [31:0] instret
);

    fetch_state_t r_state;
    logic [31:0]  r_pc_next;
    logic [31:0]  r_instr;
    logic [31:0]  r_instret;
    logic         r_pc_en;
    logic         r_instr_valid;
    logic         r_trap;
    logic         r_fault;
    logic         r_halted;

    logic [31:0]  w_seq_pc;
    logic [31:0]  w_raw_tgt;
    logic         w_misaligned;
    logic         w_wd_clear;
    logic         w_wd_count;
    logic         w_wd_expired;

    // Next-PC candidate: sequential address wraps naturally at 2^32.
    assign w_seq_pc     = pc + INSTR_BYTES;
    assign w_raw_tgt    = redirect ? redirect_target : w_seq_pc;
    assign w_misaligned = is_misaligned(w_raw_tgt);

    // Watchdog only runs while waiting in FETCH; stalled cycles do not count.
    assign w_wd_clear = (r_state != FETCH);
    assign w_wd_count = (r_state == FETCH) && !stall && !imem_valid;

    fetch_watchdog #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_wd_clear),
        .i_count   (w_wd_count),
        .o_expired (w_wd_expired)
    );

    // Sequencer FSM with all registered outputs updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_instr       <= '0;
            r_pc_next     <= RESET_PC;
            r_instret     <= '0;
            r_pc_en       <= 1'b0;
            r_instr_valid <= 1'b0;
            r_trap        <= 1'b0;
            r_fault       <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_pc_en       <= 1'b0;
            r_instr_valid <= 1'b0;
            r_trap        <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (imem_valid && !stall) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= EXEC;
                    end else if (w_wd_expired) begin
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end
                end
                EXEC: begin
                    if (ex_done) begin
                        if (halt) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else begin
                            r_pc_next <= w_misaligned ? TRAP_VEC : w_raw_tgt;
                            r_trap    <= w_misaligned;
                            r_pc_en   <= 1'b1;
                            r_instret <= r_instret + 32'd1;
                            r_state   <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    r_state <= FETCH;
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Request is withdrawn in the same cycle a stall appears.
    assign imem_req      = (r_state == FETCH) && !stall;
    assign imem_addr     = pc;

    assign pc_next       = r_pc_next;
    assign pc_en         = r_pc_en;
    assign instr         = r_instr;
    assign instr_valid   = r_instr_valid;
    assign misalign_trap = r_trap;
    assign fetch_fault   = r_fault;
    assign halted        = r_halted;
    assign instret       = r_instret;

endmodule
`default_nettype wire
